// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - handshaked ALU operation sequencer with register file and flag register
//
// Purpose: accepts one ALU operation at a time over a valid/ready handshake,
// reads operands from an internal register file (B optionally an immediate),
// executes it over four cycles (IDLE -> READ -> EXEC -> WB), writes back the
// result and commits the flag register in WB.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   op_valid / op_ready                 request handshake (ready only in IDLE)
//   op_control, op_regA, op_regB,
//   op_dest, op_use_imm, op_imm         request fields, captured on accept
//   result_valid, result, op_illegal    WB pulse, held result, illegal-control pulse
//   carryFlag, lowFlag, overflowFlag,
//   negFlag, zeroFlag                   committed flag register
//   dbg_addr / dbg_data                 combinational register-file read port
module alu_op_sequencer #(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [3:0]               op_control,
  input  logic [REG_ADDR_BITS-1:0] op_regA,
  input  logic [REG_ADDR_BITS-1:0] op_regB,
  input  logic [REG_ADDR_BITS-1:0] op_dest,
  input  logic                     op_use_imm,
  input  logic [REG_WIDTH-1:0]     op_imm,
  output logic                     result_valid,
  output logic [REG_WIDTH-1:0]     result,
  output logic                     op_illegal,
  output logic                     carryFlag,
  output logic                     lowFlag,
  output logic                     overflowFlag,
  output logic                     negFlag,
  output logic                     zeroFlag,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [REG_WIDTH-1:0]     dbg_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_BITS;
  localparam int MSB      = REG_WIDTH - 1;
  localparam logic [REG_WIDTH-1:0] LP_WIDTH = REG_WIDTH'(REG_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDU = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBU = 4'b0011;
  localparam logic [3:0] OP_CMP  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LSH  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_ready;
  logic   w_result_valid;

  logic [REG_WIDTH-1:0]     r_regs [NUM_REGS];

  // Captured request fields
  logic [3:0]               r_ctl;
  logic [REG_ADDR_BITS-1:0] r_rega;
  logic [REG_ADDR_BITS-1:0] r_regb;
  logic [REG_ADDR_BITS-1:0] r_dest;
  logic                     r_use_imm;
  logic [REG_WIDTH-1:0]     r_imm;

  // Operands latched in READ
  logic [REG_WIDTH-1:0]     r_a;
  logic [REG_WIDTH-1:0]     r_b;

  // EXEC results waiting for WB
  logic [REG_WIDTH-1:0]     r_res;
  logic                     r_wr;
  logic                     r_ill;
  logic                     r_nc, r_nl, r_nf, r_nn, r_nz;

  // Committed flags
  logic                     r_c, r_l, r_f, r_n, r_z;

  // ALU combinational outputs
  logic [REG_WIDTH:0]       w_sum;
  logic [REG_WIDTH:0]       w_diff;
  logic                     w_borrow;
  logic                     w_add_ovf;
  logic                     w_sub_ovf;
  logic                     w_slt;
  logic [REG_WIDTH-1:0]     w_mag;
  logic                     w_shift_big;
  logic [REG_WIDTH-1:0]     w_res;
  logic                     w_wr;
  logic                     w_ill;
  logic                     w_nc, w_nl, w_nf, w_nn, w_nz;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_ready        = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (op_valid) w_next = S_READ;
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB: begin
        w_result_valid = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- ALU ----------------
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff   = {1'b0, r_a} - {1'b0, r_b};
  assign w_borrow = w_diff[REG_WIDTH];
  // Signed overflow: operands agree (add) / disagree (sub) in sign and the result sign differs from A.
  assign w_add_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB]  != r_a[MSB]);
  assign w_sub_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
  // Signed less-than: differing signs decide directly, otherwise the unsigned borrow does.
  assign w_slt     = (r_a[MSB] != r_b[MSB]) ? r_a[MSB] : w_borrow;
  // Shift magnitude; the most negative B negates to itself, which is still >= width.
  assign w_mag       = r_b[MSB] ? (-r_b) : r_b;
  assign w_shift_big = (w_mag >= LP_WIDTH);

  always_comb begin
    w_res = '0;
    w_wr  = 1'b1;
    w_ill = 1'b0;
    w_nc  = r_c;
    w_nl  = r_l;
    w_nf  = r_f;
    w_nn  = r_n;
    w_nz  = r_z;
    case (r_ctl)
      OP_ADD: begin
        w_res = w_sum[REG_WIDTH-1:0];
        w_nc  = w_sum[REG_WIDTH];
        w_nf  = w_add_ovf;
      end
      OP_ADDU: begin
        w_res = w_sum[REG_WIDTH-1:0];
        w_nc  = w_sum[REG_WIDTH];
      end
      OP_SUB: begin
        w_res = w_diff[REG_WIDTH-1:0];
        w_nc  = w_borrow;
        w_nf  = w_sub_ovf;
      end
      OP_SUBU: begin
        w_res = w_diff[REG_WIDTH-1:0];
        w_nc  = w_borrow;
      end
      OP_CMP: begin
        w_res = w_diff[REG_WIDTH-1:0];
        w_wr  = 1'b0;
        w_nz  = (r_a == r_b);
        w_nl  = w_borrow;
        w_nn  = w_slt;
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_LSH: begin
        if (w_shift_big)   w_res = '0;
        else if (r_b[MSB]) w_res = r_a >> w_mag;
        else               w_res = r_a << w_mag;
      end
      default: begin
        w_wr  = 1'b0;
        w_ill = 1'b1;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_ctl     <= '0;
      r_rega    <= '0;
      r_regb    <= '0;
      r_dest    <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_wr      <= 1'b0;
      r_ill     <= 1'b0;
      r_nc <= 1'b0; r_nl <= 1'b0; r_nf <= 1'b0; r_nn <= 1'b0; r_nz <= 1'b0;
      r_c  <= 1'b0; r_l  <= 1'b0; r_f  <= 1'b0; r_n  <= 1'b0; r_z  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_ctl     <= op_control;
            r_rega    <= op_regA;
            r_regb    <= op_regB;
            r_dest    <= op_dest;
            r_use_imm <= op_use_imm;
            r_imm     <= op_imm;
          end
        end
        S_READ: begin
          r_a <= r_regs[r_rega];
          r_b <= r_use_imm ? r_imm : r_regs[r_regb];
        end
        S_EXEC: begin
          r_res <= w_res;
          r_wr  <= w_wr;
          r_ill <= w_ill;
          r_nc <= w_nc; r_nl <= w_nl; r_nf <= w_nf; r_nn <= w_nn; r_nz <= w_nz;
        end
        S_WB: begin
          if (r_wr) r_regs[r_dest] <= r_res;
          // Illegal ops carry the unchanged flags as candidates, so the commit is unconditional.
          r_c <= r_nc; r_l <= r_nl; r_f <= r_nf; r_n <= r_nn; r_z <= r_nz;
        end
        default: ;
      endcase
    end
  end

  assign op_ready     = w_ready;
  assign result_valid = w_result_valid;
  assign op_illegal   = w_result_valid & r_ill;
  assign result       = r_res;
  assign carryFlag    = r_c;
  assign lowFlag      = r_l;
  assign overflowFlag = r_f;
  assign negFlag      = r_n;
  assign zeroFlag     = r_z;
  assign dbg_data     = r_regs[dbg_addr];

endmodule
